// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID/EX stage and its neighbours.
//   REG_ADDR_W / DATA_W : default register-index and operand widths
//   ZERO_REG            : hard-wired zero register; never a real dependency
//   FWD_*               : forward-select codes shared with the forwarding unit
//   upd_e               : what the ID/EX register does on the next edge
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Listed in priority order (reset is handled directly in the register)
  typedef enum logic [1:0] {
    UPD_FLUSH,
    UPD_HOLD,
    UPD_BUBBLE,
    UPD_CAPTURE
  } upd_e;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Bundle between the ID stage / EX control and the ID/EX pipeline register.
//   master : ID side; drives IF_ID_*, flush, ex_busy; sees ID_EX_*, stall, stall_cnt
//   slave  : the ID/EX register itself
interface id_ex_stage_reg_if #(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
  parameter int DATA_W     = pipe_pkg::DATA_W,
  parameter int CTRL_W     = 8,
  parameter int CNT_W      = 16
);

  logic                  IF_ID_valid;
  logic [REG_ADDR_W-1:0] IF_ID_rsA;
  logic [REG_ADDR_W-1:0] IF_ID_rsB;
  logic                  IF_ID_useA;
  logic                  IF_ID_useB;
  logic [REG_ADDR_W-1:0] IF_ID_Rd;
  logic [DATA_W-1:0]     IF_ID_dataA;
  logic [DATA_W-1:0]     IF_ID_dataB;
  logic [DATA_W-1:0]     IF_ID_imm;
  logic                  IF_ID_RegWrite;
  logic                  IF_ID_MemRead;
  logic [CTRL_W-1:0]     IF_ID_ctrl;
  logic                  flush;
  logic                  ex_busy;

  logic                  ID_EX_valid;
  logic [REG_ADDR_W-1:0] ID_EX_rsA;
  logic [REG_ADDR_W-1:0] ID_EX_rsB;
  logic [REG_ADDR_W-1:0] ID_EX_Rd;
  logic [DATA_W-1:0]     ID_EX_dataA;
  logic [DATA_W-1:0]     ID_EX_dataB;
  logic [DATA_W-1:0]     ID_EX_imm;
  logic                  ID_EX_RegWrite;
  logic                  ID_EX_MemRead;
  logic [CTRL_W-1:0]     ID_EX_ctrl;
  logic                  stall;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output IF_ID_valid, IF_ID_rsA, IF_ID_rsB, IF_ID_useA, IF_ID_useB, IF_ID_Rd,
           IF_ID_dataA, IF_ID_dataB, IF_ID_imm, IF_ID_RegWrite, IF_ID_MemRead,
           IF_ID_ctrl, flush, ex_busy,
    input  ID_EX_valid, ID_EX_rsA, ID_EX_rsB, ID_EX_Rd, ID_EX_dataA, ID_EX_dataB,
           ID_EX_imm, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_ctrl, stall, stall_cnt
  );

  modport slave (
    input  IF_ID_valid, IF_ID_rsA, IF_ID_rsB, IF_ID_useA, IF_ID_useB, IF_ID_Rd,
           IF_ID_dataA, IF_ID_dataB, IF_ID_imm, IF_ID_RegWrite, IF_ID_MemRead,
           IF_ID_ctrl, flush, ex_busy,
    output ID_EX_valid, ID_EX_rsA, ID_EX_rsB, ID_EX_Rd, ID_EX_dataA, ID_EX_dataB,
           ID_EX_imm, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_ctrl, stall, stall_cnt
  );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard detector (purely combinational).
//   exValid_i, exMemRead_i, exRd_i : instruction currently in EX
//   idValid_i, idRsA_i, idRsB_i,
//   idUseA_i, idUseB_i             : instruction currently in ID
//   lu_o                           : ID needs a value a load in EX has not produced yet
module load_use_detect #(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
  input  logic                  exValid_i,
  input  logic                  exMemRead_i,
  input  logic [REG_ADDR_W-1:0] exRd_i,
  input  logic                  idValid_i,
  input  logic [REG_ADDR_W-1:0] idRsA_i,
  input  logic [REG_ADDR_W-1:0] idRsB_i,
  input  logic                  idUseA_i,
  input  logic                  idUseB_i,
  output logic                  lu_o
);

  import pipe_pkg::*;

  logic exIsLoad;
  logic hitA;
  logic hitB;

  // A load writing the zero register produces nothing to wait for, and an
  // operand the consumer does not read cannot create a dependency.
  always_comb begin
    exIsLoad = exValid_i & exMemRead_i & (exRd_i != REG_ADDR_W'(ZERO_REG));
    hitA     = idUseA_i & (idRsA_i == exRd_i);
    hitB     = idUseB_i & (idRsB_i == exRd_i);
    lu_o     = exIsLoad & idValid_i & (hitA | hitB);
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of id_ex_stage_reg_if
//              in : IF_ID_* decoded instruction, flush (EX branch taken),
//                   ex_busy (multi-cycle EX op)
//              out: ID_EX_* registered instruction, stall (hold PC and IF/ID),
//                   stall_cnt (saturating count of load-use bubbles)
module id_ex_stage_reg #(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
  parameter int DATA_W     = pipe_pkg::DATA_W,
  parameter int CTRL_W     = 8,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  id_ex_stage_reg_if.slave bus
);

  import pipe_pkg::*;

  logic                  valid_q,    valid_d;
  logic [REG_ADDR_W-1:0] rsA_q,      rsA_d;
  logic [REG_ADDR_W-1:0] rsB_q,      rsB_d;
  logic [REG_ADDR_W-1:0] rd_q,       rd_d;
  logic [DATA_W-1:0]     dataA_q,    dataA_d;
  logic [DATA_W-1:0]     dataB_q,    dataB_d;
  logic [DATA_W-1:0]     imm_q,      imm_d;
  logic                  regWrite_q, regWrite_d;
  logic                  memRead_q,  memRead_d;
  logic [CTRL_W-1:0]     ctrl_q,     ctrl_d;
  logic [CNT_W-1:0]      stallCnt_q, stallCnt_d;

  logic lu;
  upd_e upd;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_loadUseDetect (
    .exValid_i   (valid_q),
    .exMemRead_i (memRead_q),
    .exRd_i      (rd_q),
    .idValid_i   (bus.IF_ID_valid),
    .idRsA_i     (bus.IF_ID_rsA),
    .idRsB_i     (bus.IF_ID_rsB),
    .idUseA_i    (bus.IF_ID_useA),
    .idUseB_i    (bus.IF_ID_useB),
    .lu_o        (lu)
  );

  // Flush kills the ID instruction even while EX is busy; a hold masks the
  // load-use check so no bubble is charged until EX frees up.
  always_comb begin
    if (bus.flush)        upd = UPD_FLUSH;
    else if (bus.ex_busy) upd = UPD_HOLD;
    else if (lu)          upd = UPD_BUBBLE;
    else                  upd = UPD_CAPTURE;
  end

  assign bus.stall = ~rst & ~bus.flush & (lu | bus.ex_busy);

  // Next-state for the payload. A bubble is an all-zero entry, and an
  // invalid ID slot is captured as a bubble so stale RegWrite/MemRead
  // can never leak into EX.
  always_comb begin
    valid_d    = '0;
    rsA_d      = '0;
    rsB_d      = '0;
    rd_d       = '0;
    dataA_d    = '0;
    dataB_d    = '0;
    imm_d      = '0;
    regWrite_d = '0;
    memRead_d  = '0;
    ctrl_d     = '0;
    stallCnt_d = stallCnt_q;
    unique case (upd)
      UPD_HOLD: begin
        valid_d    = valid_q;
        rsA_d      = rsA_q;
        rsB_d      = rsB_q;
        rd_d       = rd_q;
        dataA_d    = dataA_q;
        dataB_d    = dataB_q;
        imm_d      = imm_q;
        regWrite_d = regWrite_q;
        memRead_d  = memRead_q;
        ctrl_d     = ctrl_q;
      end
      UPD_BUBBLE: begin
        if (stallCnt_q != '1) stallCnt_d = stallCnt_q + CNT_W'(1);
      end
      UPD_CAPTURE: begin
        if (bus.IF_ID_valid) begin
          valid_d    = 1'b1;
          rsA_d      = bus.IF_ID_rsA;
          rsB_d      = bus.IF_ID_rsB;
          rd_d       = bus.IF_ID_Rd;
          dataA_d    = bus.IF_ID_dataA;
          dataB_d    = bus.IF_ID_dataB;
          imm_d      = bus.IF_ID_imm;
          regWrite_d = bus.IF_ID_RegWrite;
          memRead_d  = bus.IF_ID_MemRead;
          ctrl_d     = bus.IF_ID_ctrl;
        end
      end
      default: begin
      end
    endcase
  end

  // State register; reset also drops any bubble that was about to be inserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      rsA_q      <= '0;
      rsB_q      <= '0;
      rd_q       <= '0;
      dataA_q    <= '0;
      dataB_q    <= '0;
      imm_q      <= '0;
      regWrite_q <= '0;
      memRead_q  <= '0;
      ctrl_q     <= '0;
      stallCnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      rsA_q      <= rsA_d;
      rsB_q      <= rsB_d;
      rd_q       <= rd_d;
      dataA_q    <= dataA_d;
      dataB_q    <= dataB_d;
      imm_q      <= imm_d;
      regWrite_q <= regWrite_d;
      memRead_q  <= memRead_d;
      ctrl_q     <= ctrl_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign bus.ID_EX_valid    = valid_q;
  assign bus.ID_EX_rsA      = rsA_q;
  assign bus.ID_EX_rsB      = rsB_q;
  assign bus.ID_EX_Rd       = rd_q;
  assign bus.ID_EX_dataA    = dataA_q;
  assign bus.ID_EX_dataB    = dataB_q;
  assign bus.ID_EX_imm      = imm_q;
  assign bus.ID_EX_RegWrite = regWrite_q;
  assign bus.ID_EX_MemRead  = memRead_q;
  assign bus.ID_EX_ctrl     = ctrl_q;
  assign bus.stall_cnt      = stallCnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg, built with a 2-bit stall counter so
// saturation is reachable in a handful of bubbles.
module tb_id_ex_stage_reg;

  localparam int PW = 122;

  logic clk = 1'b0;
  logic rst;

  int vectors = 0;
  int miscompares = 0;
  int expCnt = 0;

  logic [PW-1:0] curVec;
  logic [PW-1:0] heldVec;
  logic [PW-1:0] idEx;

  id_ex_stage_reg_if #(.REG_ADDR_W(5), .DATA_W(32), .CTRL_W(8), .CNT_W(2)) bus ();

  id_ex_stage_reg #(.REG_ADDR_W(5), .DATA_W(32), .CTRL_W(8), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign idEx = {bus.ID_EX_valid, bus.ID_EX_rsA, bus.ID_EX_rsB, bus.ID_EX_Rd,
                 bus.ID_EX_dataA, bus.ID_EX_dataB, bus.ID_EX_imm,
                 bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_ctrl};

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID-stage instruction and remember its registered image
  task automatic applyStimulus(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                               input logic ua, input logic ub, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic [31:0] da,
                               input logic [31:0] db, input logic [31:0] im,
                               input logic [7:0] ct);
    bus.IF_ID_valid    = v;
    bus.IF_ID_rsA      = ra;
    bus.IF_ID_rsB      = rb;
    bus.IF_ID_useA     = ua;
    bus.IF_ID_useB     = ub;
    bus.IF_ID_Rd       = rd;
    bus.IF_ID_RegWrite = rw;
    bus.IF_ID_MemRead  = mr;
    bus.IF_ID_dataA    = da;
    bus.IF_ID_dataB    = db;
    bus.IF_ID_imm      = im;
    bus.IF_ID_ctrl     = ct;
    curVec = {v, ra, rb, rd, da, db, im, rw, mr, ct};
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.ex_busy = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 8'd0);
    tick();
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_stall_busy: got %0b expected 0", bus.stall);
    end
    tick();
    rst = 1'b0;
    bus.ex_busy = 1'b0;
    #1;
    vectors++;
    if (idEx !== '0 || bus.stall_cnt !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %h cnt %0d expected 0 cnt 0", idEx, bus.stall_cnt);
    end
    tick();
    vectors++;
    if (bus.ID_EX_valid !== 1'b0 || bus.stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL nop_after_reset: got valid %0b stall %0b expected 0 0",
               bus.ID_EX_valid, bus.stall);
    end
  endtask

  task automatic test_invalid_capture();
    applyStimulus(1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 32'hAAAA_5555,
                  32'h1234_0000, 32'hFFFF_FFF0, 8'hEE);
    tick();
    vectors++;
    if (idEx !== '0) begin
      miscompares++;
      $display("[TB] FAIL invalid_capture: got %h expected 0", idEx);
    end
  endtask

  task automatic test_load_use();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 32'h0000_1000,
                  32'd0, 32'h0000_0010, 8'hA5);
    tick();
    vectors++;
    if (idEx !== curVec) begin
      miscompares++;
      $display("[TB] FAIL load_capture: got %h expected %h", idEx, curVec);
    end
    applyStimulus(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 32'hDEAD_BEEF,
                  32'h1234_5678, 32'd0, 8'h3C);
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL lu_stall: got %0b expected 1", bus.stall);
    end
    tick();
    expCnt = 1;
    vectors++;
    if (bus.ID_EX_valid !== 1'b0 || bus.ID_EX_RegWrite !== 1'b0 || bus.stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lu_bubble: got valid %0b rw %0b stall %0b expected 0 0 0",
               bus.ID_EX_valid, bus.ID_EX_RegWrite, bus.stall);
    end
    tick();
    vectors++;
    if (idEx !== curVec || bus.ID_EX_rsA !== 5'd5 || bus.stall_cnt !== 2'(expCnt)) begin
      miscompares++;
      $display("[TB] FAIL lu_consumer_enters: got %h cnt %0d expected %h cnt %0d",
               idEx, bus.stall_cnt, curVec, expCnt);
    end
  endtask

  task automatic test_no_false_stall();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 32'd1, 32'd2, 32'd3, 8'h01);
    tick();
    applyStimulus(1'b1, 5'd0, 5'd8, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 8'h02);
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rd0_no_stall: got %0b expected 0", bus.stall);
    end
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 32'd4, 32'd5, 32'd6, 8'h03);
    tick();
    applyStimulus(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 8'h04);
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL unused_rsB_no_stall: got %0b expected 0", bus.stall);
    end
    bus.IF_ID_useB = 1'b1;
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL used_rsB_stall: got %0b expected 1", bus.stall);
    end
    applyStimulus(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 32'd7, 32'd8, 32'd9, 8'h05);
    tick();
    applyStimulus(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 8'h06);
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL alu_no_stall: got %0b expected 0", bus.stall);
    end
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 32'd1, 32'd2, 32'd3, 8'h11);
    tick();
    applyStimulus(1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 32'd9, 32'd9, 32'd9, 8'h22);
    bus.flush = 1'b1;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_stall: got %0b expected 0", bus.stall);
    end
    tick();
    bus.flush = 1'b0;
    vectors++;
    if (idEx !== '0 || bus.stall_cnt !== 2'(expCnt)) begin
      miscompares++;
      $display("[TB] FAIL flush_bubble: got %h cnt %0d expected 0 cnt %0d",
               idEx, bus.stall_cnt, expCnt);
    end
  endtask

  task automatic test_ex_busy();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 32'h4444_0000,
                  32'h0000_4444, 32'h44, 8'h44);
    tick();
    heldVec = curVec;
    bus.ex_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, (i == 1) ? 5'd9 : 5'd4, 5'(i + 20), 1'b1, 1'b0, 5'(i + 14), 1'b1,
                    1'b0, 32'(i * 3 + 1), 32'(i * 5), 32'(i), 8'(i + 8'h50));
      vectors++;
      if (bus.stall !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL busy_stall[%0d]: got %0b expected 1", i, bus.stall);
      end
      tick();
      vectors++;
      if (idEx !== heldVec || bus.stall_cnt !== 2'(expCnt)) begin
        miscompares++;
        $display("[TB] FAIL busy_hold[%0d]: got %h cnt %0d expected %h cnt %0d",
                 i, idEx, bus.stall_cnt, heldVec, expCnt);
      end
    end
    bus.ex_busy = 1'b0;
    applyStimulus(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 32'hCAFE_0001,
                  32'd0, 32'd0, 8'h77);
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_release_lu: got %0b expected 1", bus.stall);
    end
    tick();
    expCnt = 2;
    vectors++;
    if (bus.ID_EX_valid !== 1'b0 || bus.stall_cnt !== 2'(expCnt)) begin
      miscompares++;
      $display("[TB] FAIL busy_release_bubble: got valid %0b cnt %0d expected 0 cnt %0d",
               bus.ID_EX_valid, bus.stall_cnt, expCnt);
    end
    tick();
    vectors++;
    if (idEx !== curVec) begin
      miscompares++;
      $display("[TB] FAIL busy_resume_capture: got %h expected %h", idEx, curVec);
    end
  endtask

  task automatic test_back_to_back_saturation();
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 32'h3333_3333,
                  32'd0, 32'd0, 8'h33);
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.stall !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL chain_stall[%0d]: got %0b expected 1", i, bus.stall);
      end
      tick();
      expCnt = (expCnt == 3) ? 3 : expCnt + 1;
      vectors++;
      if (bus.ID_EX_valid !== 1'b0 || bus.stall !== 1'b0 || bus.stall_cnt !== 2'(expCnt)) begin
        miscompares++;
        $display("[TB] FAIL chain_bubble[%0d]: got valid %0b stall %0b cnt %0d expected 0 0 %0d",
                 i, bus.ID_EX_valid, bus.stall, bus.stall_cnt, expCnt);
      end
      tick();
      vectors++;
      if (idEx !== curVec) begin
        miscompares++;
        $display("[TB] FAIL chain_enter[%0d]: got %h expected %h", i, idEx, curVec);
      end
    end
    vectors++;
    if (bus.stall_cnt !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL cnt_saturated: got %0d expected 3", bus.stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_invalid_capture();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_ex_busy();
    test_back_to_back_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
